sub_result_fifo: RTL and testbench

SUB_RESULT_FIFO -- requirements
Module: sub_result_fifo

---
 rtl/sub_result_fifo.sv | 128 ++++++++++++
 tb/tb_sub_result_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sub_result_fifo.sv
// Result FIFO for an 8-bit subtractor: stores diff/borrow plus zero/neg flags, first-word-fall-through head, 0-cycle read latency.
// Backpressure: in_ready drops only when full (registered); optional rejected-push counter under SUB_RESULT_FIFO_DROP_CNT_EN.
module sub_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         diff_in,
  input  logic                     borrow_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_diff,
  output logic                     out_borrow,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic [$clog2(DEPTH):0]   count
`ifdef SUB_RESULT_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             neg;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push;
  logic            pop;

  // Handshake qualifiers derive from registered count only, so out_ready never reaches in_ready.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !rst;
  assign pop       = out_valid && out_ready && !rst;

  always_comb begin
    wr_entry        = '0;
    wr_entry.diff   = diff_in;
    wr_entry.borrow = borrow_in;
    wr_entry.zero   = (diff_in == '0);
    wr_entry.neg    = diff_in[WIDTH-1];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; the output mux hides stale contents when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_diff   = '0;
    out_borrow = 1'b0;
    out_zero   = 1'b0;
    out_neg    = 1'b0;
    if (out_valid) begin
      out_diff   = head.diff;
      out_borrow = head.borrow;
      out_zero   = head.zero;
      out_neg    = head.neg;
    end
  end

  assign count = count_q;

`ifdef SUB_RESULT_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_valid && !in_ready && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sub_result_fifo.sv
// Directed bench for sub_result_fifo with hand-computed expectations.
module tb_sub_result_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] diff_in;
  logic       borrow_in;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_diff;
  logic       out_borrow;
  logic       out_zero;
  logic       out_neg;
  logic [2:0] count;
`ifdef SUB_RESULT_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  sub_result_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .diff_in    (diff_in),
    .borrow_in  (borrow_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_diff   (out_diff),
    .out_borrow (out_borrow),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .count      (count)
`ifdef SUB_RESULT_FIFO_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] d, input logic b);
    diff_in   = d;
    borrow_in = b;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [7:0] d, input logic b,
                          input logic z, input logic n);
    chk({tag, ".vld"},    16'(out_valid),  16'h1);
    chk({tag, ".diff"},   16'(out_diff),   16'(d));
    chk({tag, ".borrow"}, 16'(out_borrow), 16'(b));
    chk({tag, ".zero"},   16'(out_zero),   16'(z));
    chk({tag, ".neg"},    16'(out_neg),    16'(n));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".vld"},    16'(out_valid),  16'h0);
    chk({tag, ".rdy"},    16'(in_ready),   16'h1);
    chk({tag, ".cnt"},    16'(count),      16'h0);
    chk({tag, ".diff"},   16'(out_diff),   16'h0);
    chk({tag, ".borrow"}, 16'(out_borrow), 16'h0);
    chk({tag, ".zero"},   16'(out_zero),   16'h0);
    chk({tag, ".neg"},    16'(out_neg),    16'h0);
  endtask

  initial begin
    rst       = 1'b1;
    diff_in   = 8'h3C;
    borrow_in = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk_empty("reset");
`ifdef SUB_RESULT_FIFO_DROP_CNT_EN
    chk("reset.drop", 16'(drop_cnt), 16'h0);
`endif

    // Single push, zero-latency head
    push1(8'hAA, 1'b0);
    chk_head("aa", 8'hAA, 1'b0, 1'b0, 1'b1);
    chk("aa.cnt", 16'(count), 16'h1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_empty("aa.drain");

    // Three pushes, ordered pops with flags
    push1(8'h55, 1'b0);
    push1(8'h00, 1'b0);
    push1(8'hAB, 1'b1);
    chk("three.cnt", 16'(count), 16'h3);
    chk_head("p55", 8'h55, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    chk_head("p00", 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    chk_head("pab", 8'hAB, 1'b1, 1'b0, 1'b1);
    step();
    out_ready = 1'b0;
    chk_empty("three.drain");

    // Fill, then push while full is refused
    for (int i = 0; i < 4; i++) begin
      chk("fill.rdy", 16'(in_ready), 16'h1);
      push1(8'hC1 + 8'(i), 1'(i % 2));
    end
    chk("full.cnt", 16'(count), 16'h4);
    chk("full.rdy", 16'(in_ready), 16'h0);
    diff_in   = 8'hEE;
    borrow_in = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("hold.cnt", 16'(count), 16'h4);
    chk("hold.rdy", 16'(in_ready), 16'h0);
    chk_head("hold.c1", 8'hC1, 1'b0, 1'b0, 1'b1);
`ifdef SUB_RESULT_FIFO_DROP_CNT_EN
    chk("hold.drop", 16'(drop_cnt), 16'h3);
`endif

    // Full with push and pop on the same edge: pop only
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fullpop.cnt", 16'(count), 16'h3);
    chk("fullpop.rdy", 16'(in_ready), 16'h1);
`ifdef SUB_RESULT_FIFO_DROP_CNT_EN
    chk("fullpop.drop", 16'(drop_cnt), 16'h4);
`endif
    chk_head("fullpop.c2", 8'hC2, 1'b1, 1'b0, 1'b1);
    out_ready = 1'b1;
    step();
    chk_head("fullpop.c3", 8'hC3, 1'b0, 1'b0, 1'b1);
    step();
    chk_head("fullpop.c4", 8'hC4, 1'b1, 1'b0, 1'b1);
    step();
    out_ready = 1'b0;
    chk_empty("fullpop.drain");

    // Steady push+pop at count=2 across pointer wrap
    push1(8'hF0, 1'b0);
    push1(8'hF1, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] exp_head;
      exp_head = (i == 0) ? 8'hF0 : (i == 1) ? 8'hF1 : 8'(i - 1);
      chk("stream.head", 16'(out_diff), 16'(exp_head));
      diff_in   = 8'(i + 1);
      borrow_in = 1'b0;
      in_valid  = 1'b1;
      step();
      chk("stream.cnt", 16'(count), 16'h2);
    end
    in_valid = 1'b0;
    chk("stream.tail9", 16'(out_diff), 16'h09);
    step();
    chk("stream.tailA", 16'(out_diff), 16'h0A);
    step();
    chk_empty("stream.drain");

    // Empty with out_ready high and a concurrent push
    push1(8'h7F, 1'b0);
    out_ready = 1'b0;
    chk("emptypush.cnt", 16'(count), 16'h1);
    chk_head("emptypush", 8'h7F, 1'b0, 1'b0, 1'b0);

    // Mid-operation reset with a concurrent push
    push1(8'h11, 1'b0);
    push1(8'h22, 1'b0);
    chk("prerst.cnt", 16'(count), 16'h3);
    rst       = 1'b1;
    diff_in   = 8'h33;
    in_valid  = 1'b1;
    step();
    rst       = 1'b0;
    in_valid  = 1'b0;
    chk_empty("midrst");
`ifdef SUB_RESULT_FIFO_DROP_CNT_EN
    chk("midrst.drop", 16'(drop_cnt), 16'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
